serial_rx_package: RTL and testbench
====================================

SERIAL_RX_PACKAGE -- requirements
Module: serial_rx_package

Interface
REQ-001 The block SHALL have parameter AddressWidth, default 2, meaning log2 of words per package.
REQ-002 The block SHALL have parameter WordWidth, default 8, meaning data bits per serial frame.
REQ-003 The block SHALL have parameter SerialTimerWidth, default 3, meaning log2 of clocks per serial bit.
REQ-004 The block SHALL have parameter QueueAddressWidth, default 2, meaning log2 of queue depth in packages.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, the asynchronous active-low reset.
REQ-007 The block SHALL have port rx, input, 1 bit, the serial line, which idles high and is asynchronous to clk.
REQ-008 The block SHALL have port pull, input, 1 bit, which pops the queue head.
REQ-009 The block SHALL have port Q, output, 2**AddressWidth*WordWidth bits, the queue-head package.
REQ-010 The block SHALL have port void, output, 1 bit, which is high when the queue is empty.
REQ-011 The block SHALL have port full, output, 1 bit, which is high when the queue holds 2**QueueAddressWidth packages.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized rx.
REQ-013 The bit period SHALL be P = 2**SerialTimerWidth clocks (8 at defaults).
REQ-014 The frame format SHALL be: 1 start bit (0), WordWidth data bits LSB first, 1 stop bit (1), no parity.
REQ-015 The receiver FSM SHALL have states IDLE, START, DATA and STOP.
REQ-016 In IDLE, rx=0 SHALL move the FSM to START and clear the timer.
REQ-017 In START, rx SHALL be sampled after P/2 clocks: 0 moves to DATA, 1 (false start) returns to IDLE.
REQ-018 In DATA, rx SHALL be sampled every P clocks, shifting in WordWidth bits, then the FSM moves to STOP.
REQ-019 In STOP, rx SHALL be sampled after P clocks: 1 accepts the word, 0 is a framing error that discards the word and resets the word index to 0.
REQ-020 After either STOP outcome the FSM SHALL return to IDLE; back-to-back frames with no idle gap SHALL be received.
REQ-021 Accepted words SHALL fill a package in order: word k goes to bits [(k+1)*WordWidth-1 : k*WordWidth], k = 0..2**AddressWidth-1.
REQ-022 The word index SHALL wrap to 0 after the last word.
REQ-023 When the last word of a package is accepted, the package SHALL be pushed to the queue on the same edge.
REQ-024 void SHALL fall on the following clock.
REQ-025 The queue SHALL be a FIFO with first-word-fall-through: Q equals the head package whenever void=0, and Q=0 when void=1.
REQ-026 pull with void=0 SHALL pop the head on the clock edge; pull with void=1 SHALL be ignored; pull may be held high continuously.
REQ-027 A push while full=1 with no pop SHALL drop the new package; the queue contents are unchanged.
REQ-028 A simultaneous push and pop SHALL both take effect; when full, the pop frees the slot and the push is accepted, so full stays 1.
REQ-029 Queue pointers SHALL wrap modulo 2**QueueAddressWidth; full and void SHALL be derived from an occupancy count or an extra pointer bit.

Reset
REQ-030 rst=0 SHALL asynchronously force: FSM=IDLE, timer=0, word index=0, shift register=0, synchronizer=1, queue pointers/count=0, void=1, full=0, Q=0.
REQ-031 A frame in progress at reset SHALL be discarded.
REQ-032 Operation SHALL resume on the first rising edge with rst=1.

Verification (default parameters, P=8)
REQ-033 Reset asserted mid-frame, then released -> void=1, full=0, Q=0; the next complete 4 frames are received correctly.
REQ-034 Drive frames 0x11, 0x22, 0x33, 0x44 at 8 clocks/bit, pull=0 -> void falls one clock after the 4th stop sample, Q=32'h44332211.
REQ-035 Drive 16 random words (4 packages) -> full=1 and FIFO order is kept; a 5th package is dropped; pull=1 for 4 clocks returns packages 1..4 in order, then void=1.
REQ-036 A 2-clock low glitch on idle rx -> false start, no word accepted, void stays 1.
REQ-037 A frame with stop bit 0 after 2 good words -> partial package discarded; the next 4 good frames form one package equal to exactly those words.
REQ-038 Queue full with pull=1 on the edge the 5th package completes -> full stays 1; after draining, the 5th package is the last output.

Source files
------------

// File: rtl/serial_rx_package.sv
// Serial frame receiver that packs accepted words into packages and queues them in a FWFT FIFO.
// The empty flag is named "empty" because "void" is a reserved SystemVerilog keyword.
module serial_rx_package #(
  parameter int AddressWidth      = 2,
  parameter int WordWidth         = 8,
  parameter int SerialTimerWidth  = 3,
  parameter int QueueAddressWidth = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    rx,
  input  logic                                    pull,
  output logic [(2**AddressWidth)*WordWidth-1:0]  Q,
  output logic                                    empty,
  output logic                                    full
);

  localparam int Words       = 2**AddressWidth;
  localparam int PkgWidth    = Words * WordWidth;
  localparam int Depth       = 2**QueueAddressWidth;
  localparam int CountWidth  = QueueAddressWidth + 1;
  localparam int BitCntWidth = $clog2(WordWidth) + 1;

  localparam logic [SerialTimerWidth-1:0] HalfLast  = SerialTimerWidth'((2**SerialTimerWidth) / 2 - 1);
  localparam logic [SerialTimerWidth-1:0] TimerLast = '1;
  localparam logic [AddressWidth-1:0]     LastIndex = '1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                      state, state_n;
  logic [1:0]                  sync;
  logic                        rxs;
  logic [SerialTimerWidth-1:0] timer, timer_n;
  logic [BitCntWidth-1:0]      bitcnt, bitcnt_n;
  logic [WordWidth-1:0]        shreg, shreg_n;
  logic [AddressWidth-1:0]     index, index_n;
  logic [PkgWidth-1:0]         pkg, pkg_n, pkg_word;
  logic                        push;

  logic [PkgWidth-1:0]          mem [Depth];
  logic [QueueAddressWidth-1:0] wr_ptr, rd_ptr;
  logic [CountWidth-1:0]        count;
  logic                         do_push, do_pop;

  // rx is asynchronous to clk, so only the second flop output is ever used
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], rx};
  end

  assign rxs = sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      timer  <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      index  <= '0;
      pkg    <= '0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      index  <= index_n;
      pkg    <= pkg_n;
    end
  end

  // pkg_word is the package with the just-received word merged in, so a completed
  // package can be pushed on the same edge its last word is accepted
  always_comb begin
    state_n  = state;
    timer_n  = timer + 1'b1;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    index_n  = index;
    pkg_n    = pkg;
    push     = 1'b0;
    pkg_word = pkg;
    pkg_word[index*WordWidth +: WordWidth] = shreg;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        if (timer == HalfLast) begin
          timer_n  = '0;
          bitcnt_n = '0;
          state_n  = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == TimerLast) begin
          timer_n  = '0;
          shreg_n  = {rxs, shreg[WordWidth-1:1]};
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == BitCntWidth'(WordWidth - 1)) state_n = STOP;
        end
      end
      STOP: begin
        if (timer == TimerLast) begin
          timer_n = '0;
          state_n = IDLE;
          if (rxs) begin
            pkg_n   = pkg_word;
            index_n = index + 1'b1;
            push    = (index == LastIndex);
          end else begin
            index_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A pop on the same edge frees a slot, so a push into a full queue still lands
  assign do_pop  = pull && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= pkg_word;
  end

  assign empty = (count == '0);
  assign full  = (count == CountWidth'(Depth));
  assign Q     = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_serial_rx_package.sv
// Randomized bench for serial_rx_package: frames are driven bit by bit and checked
// against a package-level queue model.
module tb_serial_rx_package;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        pull;
  logic [31:0] Q;
  logic        empty;
  logic        full;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] pkgq[$];
  logic [7:0]  cur[$];
  logic [31:0] fifth;

  serial_rx_package dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .pull  (pull),
    .Q     (Q),
    .empty (empty),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".void"}, 64'(empty), 64'(pkgq.size() == 0));
    checkOutput({tag, ".full"}, 64'(full), 64'(pkgq.size() == 4));
    checkOutput({tag, ".Q"}, 64'(Q), (pkgq.size() == 0) ? 64'd0 : 64'(pkgq[0]));
  endtask

  // Reference: a good frame appends a word; four words make a package, kept only if room
  task automatic modelFrame(input logic [7:0] w, input bit stopBit, input bit popAtPush);
    logic [31:0] p;
    if (!stopBit) begin
      cur.delete();
      return;
    end
    cur.push_back(w);
    if (cur.size() == 4) begin
      p = {cur[3], cur[2], cur[1], cur[0]};
      cur.delete();
      if (popAtPush && pkgq.size() > 0) void'(pkgq.pop_front());
      if (pkgq.size() < 4) pkgq.push_back(p);
    end
  endtask

  // Ten bits of eight clocks each; with popAtPush, pull is high only on the stop-sample edge
  task automatic applyStimulus(input logic [7:0] w, input bit stopBit, input bit popAtPush);
    logic [9:0] bits;
    bits = {stopBit, w, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      for (int c = 0; c < 8; c++) begin
        pull = popAtPush && (b == 9) && (c == 6);
        @(posedge clk);
        @(negedge clk);
      end
    end
    pull = 1'b0;
    modelFrame(w, stopBit, popAtPush);
  endtask

  task automatic idleClocks(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drainCheck(input int n, input string tag);
    pull = 1'b1;
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, ".head"}, 64'(Q), (pkgq.size() == 0) ? 64'd0 : 64'(pkgq[0]));
      @(posedge clk);
      if (pkgq.size() > 0) void'(pkgq.pop_front());
      @(negedge clk);
    end
    pull = 1'b0;
    checkState({tag, ".after"});
  endtask

  task automatic sendPackage(input bit popAtPush);
    for (int k = 0; k < 4; k++)
      applyStimulus(8'($urandom_range(0, 255)), 1'b1, popAtPush && (k == 3));
  endtask

  initial begin
    rst  = 1'b0;
    rx   = 1'b1;
    pull = 1'b0;
    repeat (3) @(negedge clk);
    checkState("reset");
    rst = 1'b1;
    idleClocks(4);

    // Reset arriving partway through a frame
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b0;
    cur.delete();
    pkgq.delete();
    repeat (3) @(negedge clk);
    checkState("midreset");
    rx  = 1'b1;
    rst = 1'b1;
    idleClocks(4);
    checkState("midreset.release");

    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0);
    checkOutput("partial.void", 64'(empty), 64'd1);
    applyStimulus(8'h44, 1'b1, 1'b0);
    checkOutput("fixed.void", 64'(empty), 64'd0);
    checkOutput("fixed.Q", 64'(Q), 64'h44332211);
    drainCheck(1, "fixed");

    // Short low glitch on an idle line must not start a word
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idleClocks(20);
    checkState("glitch");
    sendPackage(1'b0);
    checkState("afterglitch");
    drainCheck(1, "afterglitch");

    // Framing error discards the partial package
    applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    applyStimulus(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    idleClocks(16);
    checkState("framing");
    sendPackage(1'b0);
    checkState("framing.next");
    drainCheck(1, "framing");

    // Fill the queue, overflow drops the fifth package
    for (int p = 0; p < 4; p++) sendPackage(1'b0);
    checkState("fill");
    sendPackage(1'b0);
    checkState("overflow");
    drainCheck(4, "overflowdrain");

    // Full queue with a pop on the completing edge keeps the fifth package
    for (int p = 0; p < 4; p++) sendPackage(1'b0);
    checkState("fill2");
    sendPackage(1'b1);
    checkState("pushpop");
    fifth = pkgq[pkgq.size()-1];
    drainCheck(3, "pushpopdrain");
    checkOutput("fifth.Q", 64'(Q), 64'(fifth));
    drainCheck(1, "fifthdrain");

    // Pull while empty is ignored
    pull = 1'b1;
    repeat (3) @(negedge clk);
    pull = 1'b0;
    checkState("emptypull");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
